// File: rtl/esd_multichannel_ctrl_if.sv
// esd_multichannel_ctrl_if: panel-side pins and controller status outputs.
// The controller takes the slave modport; the panel/driver side takes master.
interface esd_multichannel_ctrl_if #(
    parameter int N_ESTOP = 4
);
    logic [N_ESTOP-1:0] estop_n;
    logic               ack_n;
    logic               wdg_kick;
    logic               wdg_en;
    logic               shutdown;
    logic               led;
    logic [N_ESTOP+1:0] fault_cause;
    logic [1:0]         state;
    logic               ack_rejected;

    modport master (
        output estop_n, ack_n, wdg_kick, wdg_en,
        input  shutdown, led, fault_cause, state, ack_rejected
    );

    modport slave (
        input  estop_n, ack_n, wdg_kick, wdg_en,
        output shutdown, led, fault_cause, state, ack_rejected
    );
endinterface

// File: rtl/esd_multichannel_ctrl.sv
// esd_multichannel_ctrl: N-channel emergency-shutdown controller with fast
// E-STOP trip, debounced release/ACK, watchdog and RUN blink LED.
module esd_multichannel_ctrl #(
    parameter int N_ESTOP         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYC    = 1000,
    parameter int WDG_TIMEOUT_CYC = 25_000_000,
    parameter int BLINK_HALF_CYC  = 12_500_000
) (
    input logic                    clk,
    input logic                    rst_n,
    esd_multichannel_ctrl_if.slave bus
);
    localparam int NS = N_ESTOP + 3;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int WW = $clog2(WDG_TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF_CYC + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [WW-1:0] WDG_LAST   = WW'(WDG_TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
    localparam logic [NS-1:0] SYNC_IDLE  = {1'b0, 1'b1, {N_ESTOP{1'b1}}};
    localparam logic [N_ESTOP+1:0] CAUSE_POR = {1'b1, 1'b0, {N_ESTOP{1'b0}}};

    typedef enum logic [1:0] {
        SAFE = 2'b00,
        RUN  = 2'b01,
        TRIP = 2'b10
    } state_e;

    logic [NS-1:0]      sync_q [SYNC_STAGES];
    logic [N_ESTOP-1:0] estop_s;
    logic               ack_s;
    logic               kick_s;

    logic [N_ESTOP-1:0] active_q, active_d, active_now;
    logic [DW-1:0]      rel_cnt_q [N_ESTOP];
    logic [DW-1:0]      rel_cnt_d [N_ESTOP];
    logic               ack_db_q, ack_db_d;
    logic [DW-1:0]      ack_cnt_q, ack_cnt_d;
    logic               kick_prev_q;
    logic               ack_evt, kick_evt, wdg_exp;

    state_e             state_q, state_d;
    logic [N_ESTOP+1:0] cause_q, cause_d;
    logic [WW-1:0]      wdg_q, wdg_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               led_q, led_d;
    logic               shut_q, shut_d;
    logic               rej_q, rej_d;

    assign estop_s = sync_q[SYNC_STAGES-1][N_ESTOP-1:0];
    assign ack_s   = sync_q[SYNC_STAGES-1][N_ESTOP];
    assign kick_s  = sync_q[SYNC_STAGES-1][N_ESTOP+1];

    // Assertion is taken straight from the synchroniser; only release waits.
    always_comb begin
        active_d = active_q;
        for (int i = 0; i < N_ESTOP; i++) begin
            rel_cnt_d[i] = '0;
            if (!estop_s[i]) begin
                active_d[i] = 1'b1;
            end else if (active_q[i]) begin
                if (rel_cnt_q[i] == DB_LAST) active_d[i] = 1'b0;
                else rel_cnt_d[i] = rel_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        ack_db_d  = ack_db_q;
        ack_cnt_d = '0;
        if (ack_s != ack_db_q) begin
            if (ack_cnt_q == DB_LAST) ack_db_d = ack_s;
            else ack_cnt_d = ack_cnt_q + 1'b1;
        end
    end

    assign ack_evt    = ~ack_db_q & ack_db_d;
    assign kick_evt   = kick_s & ~kick_prev_q;
    assign active_now = active_q | ~estop_s;
    assign wdg_exp    = (state_q == RUN) && bus.wdg_en &&
                        (wdg_q == WDG_LAST) && !kick_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SAFE;
        end else begin
            state_q <= state_d;
        end
    end

    // A cause present in the ACK cycle blocks RUN even before active_q sees it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:        if (|active_now || wdg_exp) state_d = TRIP;
            SAFE, TRIP: if (ack_evt && active_now == '0) state_d = RUN;
            default:    state_d = SAFE;
        endcase
    end

    always_comb begin
        cause_d = cause_q;
        rej_d   = 1'b0;
        wdg_d   = '0;
        blink_d = '0;
        led_d   = 1'b1;
        shut_d  = (state_d != RUN);
        if (state_q == RUN && bus.wdg_en && !kick_evt) wdg_d = wdg_q + 1'b1;
        if (state_q == RUN && state_d == TRIP) begin
            cause_d = cause_q | {1'b0, wdg_exp, active_now};
        end else if (state_q != RUN && state_d == RUN) begin
            cause_d = '0;
        end else if (state_q == TRIP) begin
            cause_d = cause_q | {2'b00, active_now};
        end
        if (state_q != RUN && ack_evt && active_now != '0) rej_d = 1'b1;
        if (state_d == RUN) begin
            led_d = 1'b0;
            if (state_q == RUN) begin
                led_d = led_q;
                if (blink_q == BLINK_LAST) led_d = ~led_q;
                else blink_d = blink_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_IDLE;
            for (int i = 0; i < N_ESTOP; i++) rel_cnt_q[i] <= '0;
            active_q    <= '0;
            ack_db_q    <= 1'b1;
            ack_cnt_q   <= '0;
            kick_prev_q <= 1'b0;
            cause_q     <= CAUSE_POR;
            wdg_q       <= '0;
            blink_q     <= '0;
            led_q       <= 1'b1;
            shut_q      <= 1'b1;
            rej_q       <= 1'b0;
        end else begin
            sync_q[0] <= {bus.wdg_kick, bus.ack_n, bus.estop_n};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < N_ESTOP; i++) rel_cnt_q[i] <= rel_cnt_d[i];
            active_q    <= active_d;
            ack_db_q    <= ack_db_d;
            ack_cnt_q   <= ack_cnt_d;
            kick_prev_q <= kick_s;
            cause_q     <= cause_d;
            wdg_q       <= wdg_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
            shut_q      <= shut_d;
            rej_q       <= rej_d;
        end
    end

    assign bus.shutdown     = shut_q;
    assign bus.led          = led_q;
    assign bus.fault_cause  = cause_q;
    assign bus.state        = state_q;
    assign bus.ack_rejected = rej_q;
endmodule

// File: tb/tb_esd_multichannel_ctrl.sv
// tb_esd_multichannel_ctrl: directed/randomised bench for the ESD controller
// with a rule-level reference model of state and fault causes.
`timescale 1ns/1ps
module tb_esd_multichannel_ctrl;
    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DB = 8;
    localparam int WT = 200;
    localparam int BH = 10;
    localparam int WDG_LAT = SS + WT + 1;
    localparam logic [1:0] S_SAFE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_TRIP = 2'b10;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [1:0]   m_state;
    logic [N+1:0] m_cause;
    logic [N-1:0] m_held;

    esd_multichannel_ctrl_if #(.N_ESTOP(N)) bus ();

    esd_multichannel_ctrl #(
        .N_ESTOP(N), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB),
        .WDG_TIMEOUT_CYC(WT), .BLINK_HALF_CYC(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: spec rules over held buttons, state and causes.
    task automatic m_reset();
        m_state = S_SAFE;
        m_cause = {1'b1, 1'b0, {N{1'b0}}};
        m_held  = '0;
    endtask

    task automatic m_press(input logic [N-1:0] m);
        m_held |= m;
        if (m_state != S_SAFE) begin
            m_cause |= {2'b00, m};
            m_state = S_TRIP;
        end
    endtask

    task automatic m_release(input logic [N-1:0] m);
        m_held &= ~m;
    endtask

    task automatic m_wdg_trip();
        m_cause[N] = 1'b1;
        m_state = S_TRIP;
    endtask

    task automatic m_ack(output logic rej);
        rej = 1'b0;
        if (m_state != S_RUN) begin
            if (m_held == '0) begin
                m_state = S_RUN;
                m_cause = '0;
            end else begin
                rej = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"}, 32'(bus.state), 32'(m_state));
        check({tag, ".cause"}, 32'(bus.fault_cause), 32'(m_cause));
        check({tag, ".shutdown"}, 32'(bus.shutdown), 32'(m_state != S_RUN));
        if (m_state != S_RUN) check({tag, ".led"}, 32'(bus.led), 32'd1);
    endtask

    task automatic do_ack(input string tag, output int lat);
        int   rej_cnt;
        logic exp_rej;
        rej_cnt = 0;
        lat = -1;
        bus.ack_n = 1'b0;
        repeat (20) begin
            tick();
            rej_cnt += int'(bus.ack_rejected);
        end
        bus.ack_n = 1'b1;
        m_ack(exp_rej);
        for (int c = 1; c <= 16; c++) begin
            tick();
            rej_cnt += int'(bus.ack_rejected);
            if (lat < 0 && bus.state == S_RUN) lat = c;
        end
        check({tag, ".rej"}, 32'(rej_cnt), 32'(exp_rej));
        check_model(tag);
        if (m_state == S_RUN)
            check({tag, ".lat"}, 32'(lat >= 1 && lat <= 12), 32'd1);
    endtask

    task automatic press(input string tag, input logic [N-1:0] m);
        int   lat;
        logic was_run;
        lat = -1;
        was_run = (m_state == S_RUN);
        bus.estop_n &= ~m;
        m_press(m);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (lat < 0 && bus.shutdown) lat = c;
        end
        if (was_run)
            check({tag, ".lat"}, 32'(lat >= 1 && lat <= SS + 2), 32'd1);
        check_model(tag);
    endtask

    task automatic release_ch(input logic [N-1:0] m);
        bus.estop_n |= m;
        repeat (DB + SS + 4) tick();
        m_release(m);
    endtask

    initial begin
        int lat;
        int trip_at;
        int bad;
        int gap;
        int rej_cnt;
        logic exp_rej;
        logic [N-1:0] m;
        checks   = 0;
        failures = 0;
        bus.estop_n  = '1;
        bus.ack_n    = 1'b1;
        bus.wdg_kick = 1'b0;
        bus.wdg_en   = 1'b0;
        m_reset();

        // t1: reset values, then idle with no ACK
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        check_model("t1.rst");
        check("t1.rst.rej", 32'(bus.ack_rejected), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (500) begin
            tick();
            if (!bus.shutdown || bus.state != S_SAFE) bad++;
        end
        check("t1.idle_bad", 32'(bad), 32'd0);
        check_model("t1");

        // simultaneous E-STOP and ACK event: E-STOP wins
        m = 4'b1 << $urandom_range(0, N - 1);
        bus.ack_n = 1'b0;
        repeat (20) tick();
        bus.ack_n = 1'b1;
        repeat (7) tick();
        bus.estop_n &= ~m;
        m_press(m);
        m_ack(exp_rej);
        rej_cnt = 0;
        repeat (10) begin
            tick();
            rej_cnt += int'(bus.ack_rejected);
        end
        check("sim.rej", 32'(rej_cnt), 32'(exp_rej));
        check_model("sim");
        release_ch(m);

        // t2: ACK into RUN, LED blink with kicks every 50 cycles
        bus.wdg_en = 1'b1;
        do_ack("t2", lat);
        for (int k = 0; k < 100; k++) begin
            bus.wdg_kick = 1'((k % 50) < 2);
            check("t2.led", 32'(bus.led), 32'(((16 - lat + k) / BH) % 2));
            tick();
        end
        for (int r = 0; r < 6; r++) begin
            gap = int'($urandom_range(20, 150));
            bus.wdg_kick = 1'b1;
            repeat (2) tick();
            bus.wdg_kick = 1'b0;
            repeat (gap - 2) tick();
            check("t2.kicked_run", 32'(bus.state), 32'(S_RUN));
        end

        // t4: kick on the last counter value wins; then silence trips
        bus.wdg_kick = 1'b1;
        trip_at = -1;
        for (int c = 1; c <= 460 && trip_at < 0; c++) begin
            tick();
            if (c == 2 || c == 202) bus.wdg_kick = 1'b0;
            if (c == 200) bus.wdg_kick = 1'b1;
            if (c == WDG_LAT) check("t4.kick_wins", 32'(bus.shutdown), 32'd0);
            if (bus.shutdown) trip_at = c;
        end
        check("t4.trip_at", 32'(trip_at), 32'(200 + WDG_LAT));
        m_wdg_trip();
        check_model("t4");
        bus.wdg_en = 1'b0;
        do_ack("t4.ack", lat);

        // watchdog expiry coinciding with an E-STOP latches both causes
        m = 4'b1 << $urandom_range(0, N - 1);
        bus.wdg_en = 1'b1;
        bus.wdg_kick = 1'b1;
        trip_at = -1;
        for (int c = 1; c <= 260 && trip_at < 0; c++) begin
            tick();
            if (c == 2) bus.wdg_kick = 1'b0;
            if (c == WDG_LAT - 1 - SS) bus.estop_n &= ~m;
            if (bus.shutdown) trip_at = c;
        end
        check("t4b.trip_at", 32'(trip_at), 32'(WDG_LAT));
        m_wdg_trip();
        m_press(m);
        check_model("t4b");
        bus.wdg_en = 1'b0;
        release_ch(m);
        do_ack("t4b.ack", lat);

        // watchdog disabled: long RUN without kicks
        repeat (300) tick();
        check_model("wdg_off");

        // t3: E-STOP ch2 then a random channel, rejected ACK, release, ACK
        for (int r = 0; r < 2; r++) begin
            m = (r == 0) ? 4'b0100 : 4'(4'b1 << $urandom_range(0, N - 1));
            press("t3.press", m);
            do_ack("t3.rej", lat);
            release_ch(m);
            do_ack("t3.run", lat);
        end

        // t5: two channels, partial release, sticky new cause in TRIP
        press("t5.press", 4'b1001);
        release_ch(4'b0001);
        do_ack("t5.rej", lat);
        press("t5.add", 4'b0010);
        release_ch(4'b1010);
        do_ack("t5.run", lat);

        // t6: glitch low during release debounce keeps the channel active
        m = 4'b1 << $urandom_range(0, N - 1);
        press("t6.press", m);
        bus.ack_n = 1'b0;
        repeat (12) tick();
        bus.estop_n |= m;
        repeat (2) tick();
        bus.ack_n = 1'b1;
        m_ack(exp_rej);
        rej_cnt = 0;
        for (int c = 2; c < 24; c++) begin
            if (c == 5) bus.estop_n &= ~m;
            if (c == 6) bus.estop_n |= m;
            tick();
            rej_cnt += int'(bus.ack_rejected);
        end
        check("t6.glitch_rej", 32'(rej_cnt), 32'(exp_rej));
        check_model("t6.glitch");
        repeat (10) tick();
        m_release(m);
        do_ack("t6.run", lat);

        // t6: asynchronous reset in RUN
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_model("t6.async");
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check_model("t6.after");
        do_ack("t6.reack", lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
